// File: rtl/conv2d0_mac_pipe_pkg.sv
// Shared constants, beat sideband type and saturation helpers for the conv2d0 MAC pipeline.
package conv2d0_mac_pipe_pkg;

    localparam int DIN0_WIDTH_DEF = 8;
    localparam int DIN1_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF  = 20;
    localparam int DOUT_WIDTH_DEF = 8;
    localparam int MUL_STAGE_DEF  = 2;
    localparam int MUL_STAGE_MIN  = 1;
    localparam int MUL_STAGE_MAX  = 4;
    localparam int SAT_CALC_WIDTH = 64;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } beat_tag_t;

    typedef enum logic [1:0] {
        SAT_IN_RANGE = 2'd0,
        SAT_ABOVE    = 2'd1,
        SAT_BELOW    = 2'd2
    } sat_class_t;

    function automatic int mul_stage_clamp(input int ms);
        if (ms < MUL_STAGE_MIN) return MUL_STAGE_MIN;
        if (ms > MUL_STAGE_MAX) return MUL_STAGE_MAX;
        return ms;
    endfunction

    // Classifies v against the signed range of a w-bit result.
    function automatic sat_class_t sat_classify(input logic signed [SAT_CALC_WIDTH-1:0] v,
                                                input int unsigned w);
        logic signed [SAT_CALC_WIDTH-1:0] hi;
        logic signed [SAT_CALC_WIDTH-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return SAT_ABOVE;
        if (v < lo) return SAT_BELOW;
        return SAT_IN_RANGE;
    endfunction

endpackage

// File: rtl/conv2d0_mac_pipe_if.sv
// Beat input / result output handshake bundle of the conv2d0 MAC pipeline.
interface conv2d0_mac_pipe_if
    import conv2d0_mac_pipe_pkg::*;
#(
    parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_first;
    logic                  in_last;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  out_sat;

    modport master (
        output in_valid, in_first, in_last, din0, din1, out_ready,
        input  in_ready, out_valid, dout, out_sat
    );

    modport slave (
        input  in_valid, in_first, in_last, din0, din1, out_ready,
        output in_ready, out_valid, dout, out_sat
    );
endinterface

// File: rtl/conv2d0_mac_pipe_mul.sv
// Pipelined signed multiplier; stage 0 registers operands, later stages register the product.
module conv2d0_mac_pipe_mul
    import conv2d0_mac_pipe_pkg::*;
#(
    parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
    parameter int MUL_STAGE  = MUL_STAGE_DEF
) (
    input  logic                                   ap_clk,
    input  logic                                   ap_rst_n,
    input  logic                                   i_ce,
    input  beat_tag_t                              i_tag,
    input  logic signed [DIN0_WIDTH-1:0]           i_din0,
    input  logic signed [DIN1_WIDTH-1:0]           i_din1,
    output beat_tag_t                              o_tag,
    output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] o_prod
);
    localparam int NSTG = mul_stage_clamp(MUL_STAGE);
    localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;

    logic signed [DIN0_WIDTH-1:0] r_din0;
    logic signed [DIN1_WIDTH-1:0] r_din1;
    beat_tag_t                    r_tag;

    logic signed [PW-1:0] w_prod [0:NSTG-1];
    beat_tag_t            w_tag  [0:NSTG-1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_din0 <= '0;
            r_din1 <= '0;
            r_tag  <= '0;
        end else if (i_ce) begin
            r_din0 <= i_din0;
            r_din1 <= i_din1;
            r_tag  <= i_tag;
        end
    end

    assign w_prod[0] = PW'(r_din0) * PW'(r_din1);
    assign w_tag[0]  = r_tag;

    genvar gi;
    generate
        for (gi = 1; gi < NSTG; gi++) begin : g_stage
            logic signed [PW-1:0] r_prod;
            beat_tag_t            r_stag;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    r_prod <= '0;
                    r_stag <= '0;
                end else if (i_ce) begin
                    r_prod <= w_prod[gi-1];
                    r_stag <= w_tag[gi-1];
                end
            end

            assign w_prod[gi] = r_prod;
            assign w_tag[gi]  = r_stag;
        end
    endgenerate

    assign o_prod = w_prod[NSTG-1];
    assign o_tag  = w_tag[NSTG-1];
endmodule

// File: rtl/conv2d0_mac_pipe.sv
// Windowed signed MAC: multiplier pipe, accumulator, shift/saturate and a held output register.
module conv2d0_mac_pipe
    import conv2d0_mac_pipe_pkg::*;
#(
    parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int MUL_STAGE  = MUL_STAGE_DEF,
    parameter int SHIFT      = 0,
    parameter int SAT_EN     = 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    conv2d0_mac_pipe_if.slave bus
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam logic [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    logic                          w_ce;
    beat_tag_t                     w_in_tag;
    beat_tag_t                     w_mul_tag;
    logic signed [PW-1:0]          w_mul_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic signed [ACC_WIDTH-1:0]   w_shift;
    logic signed [SAT_CALC_WIDTH-1:0] w_s64;
    sat_class_t                    w_sat_class;
    logic                          w_ovf;
    logic [DOUT_WIDTH-1:0]         w_dout;

    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic signed [ACC_WIDTH-1:0]   r_sum;
    logic                          r_sum_vld;
    logic                          r_out_valid;
    logic [DOUT_WIDTH-1:0]         r_dout;
    logic                          r_out_sat;

    // A held, unaccepted result freezes every stage, so nothing is dropped or duplicated.
    assign w_ce         = ~(r_out_valid & ~bus.out_ready);
    assign bus.in_ready = w_ce;
    assign w_in_tag     = '{vld: bus.in_valid, first: bus.in_first, last: bus.in_last};

    conv2d0_mac_pipe_mul #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .MUL_STAGE  (MUL_STAGE)
    ) u_mul (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .i_ce     (w_ce),
        .i_tag    (w_in_tag),
        .i_din0   ($signed(bus.din0)),
        .i_din1   ($signed(bus.din1)),
        .o_tag    (w_mul_tag),
        .o_prod   (w_mul_prod)
    );

    assign w_prod_ext = ACC_WIDTH'(w_mul_prod);
    assign w_sum      = w_mul_tag.first ? w_prod_ext : r_acc + w_prod_ext;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc     <= '0;
            r_sum     <= '0;
            r_sum_vld <= 1'b0;
        end else if (w_ce) begin
            r_sum_vld <= w_mul_tag.vld & w_mul_tag.last;
            if (w_mul_tag.vld) begin
                r_acc <= w_sum;
                r_sum <= w_sum;
            end
        end
    end

    assign w_shift = r_sum >>> SHIFT;
    assign w_s64   = SAT_CALC_WIDTH'(w_shift);

    always_comb begin
        w_sat_class = sat_classify(w_s64, DOUT_WIDTH);
        w_ovf       = (w_sat_class != SAT_IN_RANGE);
        w_dout      = w_shift[DOUT_WIDTH-1:0];
        if (SAT_EN != 0) begin
            case (w_sat_class)
                SAT_ABOVE: w_dout = DOUT_MAX;
                SAT_BELOW: w_dout = DOUT_MIN;
                default:   w_dout = w_shift[DOUT_WIDTH-1:0];
            endcase
        end
    end

    // When ce is high the current result is either absent or being taken, so reload or clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_ce) begin
            r_out_valid <= r_sum_vld;
            if (r_sum_vld) begin
                r_dout    <= w_dout;
                r_out_sat <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_conv2d0_mac_pipe.sv
// Directed-vector bench for conv2d0_mac_pipe (default config plus a SHIFT=4, SAT_EN=0 instance).
module tb_conv2d0_mac_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_total = 0;
    int   n_bad   = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d0_mac_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8)) b0 ();
    conv2d0_mac_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8)) b1 ();

    conv2d0_mac_pipe #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .ACC_WIDTH(20), .DOUT_WIDTH(8),
        .MUL_STAGE(2), .SHIFT(0), .SAT_EN(1)
    ) u_dut0 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (b0)
    );

    conv2d0_mac_pipe #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .ACC_WIDTH(20), .DOUT_WIDTH(8),
        .MUL_STAGE(2), .SHIFT(4), .SAT_EN(0)
    ) u_dut1 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (b1)
    );

    typedef struct {
        logic [7:0] dout;
        logic       sat;
        int         cyc;
    } rec_t;

    rec_t q0[$];

    // Records every result transfer of the default instance.
    always @(negedge clk) begin
        if (rst_n && b0.out_valid && b0.out_ready)
            q0.push_back('{dout: b0.dout, sat: b0.out_sat, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat on b0 and returns 1 ns after the edge that accepted it.
    task automatic beat(input int d0, input int d1, input logic f, input logic l);
        bit ok;
        ok = 1'b0;
        b0.din0     = 8'(d0);
        b0.din1     = 8'(d1);
        b0.in_first = f;
        b0.in_last  = l;
        b0.in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = b0.in_ready;
        end
        if (!ok) chk("beat_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        b0.in_valid = 1'b0;
        $display("beat d0=%0d d1=%0d first=%0b last=%0b accepted at edge %0d", d0, d1, f, l, acc_cyc);
    endtask

    task automatic wait_q(input int n);
        for (int t = 0; t < 60 && q0.size() < n; t++) begin
            @(negedge clk);
            #1;
        end
    endtask

    int   s_d0   [4] = '{-128, 127, -128, -43};
    int   s_d1   [4] = '{-128,   1,    1,   3};
    logic [7:0] s_out [4] = '{8'h7F, 8'h7F, 8'h80, 8'h80};
    logic s_sat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int   n_d0   [3] = '{100, -7, 127};
    int   n_d1   [3] = '{100,  3, 127};
    logic [7:0] n_out [3] = '{8'h71, 8'hFE, 8'hF0};
    logic n_sat  [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        b0.in_valid = 1'b0; b0.in_first = 1'b0; b0.in_last = 1'b0;
        b0.din0 = '0; b0.din1 = '0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_first = 1'b0; b1.in_last = 1'b0;
        b1.din0 = '0; b1.din1 = '0; b1.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
        chk("rst_dout",      32'(b0.dout),      32'd0);
        chk("rst_out_sat",   32'(b0.out_sat),   32'd0);
        chk("rst_in_ready",  32'(b0.in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // Single-beat windows: saturation boundaries and latency
        for (int i = 0; i < 4; i++) begin
            q0.delete();
            beat(s_d0[i], s_d1[i], 1'b1, 1'b1);
            wait_q(1);
            repeat (4) tick();
            chk("single_count",   32'(q0.size()), 32'd1);
            chk("single_dout",    32'(q0[0].dout), 32'(s_out[i]));
            chk("single_sat",     32'(q0[0].sat),  32'(s_sat[i]));
            chk("single_latency", 32'(q0[0].cyc - acc_cyc), 32'd3);
            $display("single %0d*%0d -> dout=0x%0h sat=%0b", s_d0[i], s_d1[i], q0[0].dout, q0[0].sat);
        end

        // 3-beat window
        q0.delete();
        beat(3, 4, 1'b1, 1'b0);
        beat(-2, 5, 1'b0, 1'b0);
        beat(7, -1, 1'b0, 1'b1);
        wait_q(1);
        repeat (5) tick();
        chk("win3_count", 32'(q0.size()), 32'd1);
        chk("win3_dout",  32'(q0[0].dout), 32'h0FB);
        chk("win3_sat",   32'(q0[0].sat),  32'd0);
        $display("win3 -> dout=0x%0h sat=%0b", q0[0].dout, q0[0].sat);

        // Back-to-back windows with a stalled consumer
        q0.delete();
        b0.out_ready = 1'b0;
        fork
            begin
                beat(1, 2, 1'b1, 1'b0);
                beat(3, 4, 1'b0, 1'b1);
                beat(5, 6, 1'b1, 1'b0);
                beat(-1, 2, 1'b0, 1'b1);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 40 && !seen; t++) begin
                    @(negedge clk);
                    seen = b0.out_valid;
                end
                chk("stall_seen", 32'(seen), 32'd1);
                for (int i = 0; i < 6; i++) begin
                    chk("stall_in_ready",  32'(b0.in_ready),  32'd0);
                    chk("stall_out_valid", 32'(b0.out_valid), 32'd1);
                    chk("stall_dout",      32'(b0.dout),      32'd14);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                b0.out_ready = 1'b1;
            end
        join
        wait_q(2);
        repeat (5) tick();
        chk("stall_count",  32'(q0.size()),  32'd2);
        chk("stall_first",  32'(q0[0].dout), 32'd14);
        chk("stall_second", 32'(q0[1].dout), 32'd28);
        $display("stall -> results %0d then %0d", q0[0].dout, q0[1].dout);

        // SHIFT=4, SAT_EN=0 instance: wrap, floor and overflow flag
        for (int i = 0; i < 3; i++) begin
            bit seen;
            seen = 1'b0;
            b1.din0 = 8'(n_d0[i]); b1.din1 = 8'(n_d1[i]);
            b1.in_first = 1'b1; b1.in_last = 1'b1; b1.in_valid = 1'b1;
            tick();
            b1.in_valid = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = b1.out_valid;
            end
            chk("nosat_seen", 32'(seen), 32'd1);
            chk("nosat_dout", 32'(b1.dout), 32'(n_out[i]));
            chk("nosat_sat",  32'(b1.out_sat), 32'(n_sat[i]));
            $display("nosat %0d*%0d -> dout=0x%0h sat=%0b", n_d0[i], n_d1[i], b1.dout, b1.out_sat);
            tick();
        end

        // Reset in the middle of a window while a result is held
        q0.delete();
        b0.out_ready = 1'b0;
        beat(9, 9, 1'b1, 1'b1);
        beat(1, 1, 1'b1, 1'b0);
        beat(2, 2, 1'b0, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = b0.out_valid;
            end
            chk("rstmid_held_dout", 32'(b0.dout), 32'd81);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", 32'(b0.out_valid), 32'd0);
        chk("rstmid_dout",      32'(b0.dout),      32'd0);
        chk("rstmid_out_sat",   32'(b0.out_sat),   32'd0);
        chk("rstmid_in_ready",  32'(b0.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        b0.out_ready = 1'b1;
        tick();
        beat(2, 3, 1'b0, 1'b1);
        wait_q(1);
        repeat (4) tick();
        chk("rstmid_count", 32'(q0.size()),  32'd1);
        chk("rstmid_after", 32'(q0[0].dout), 32'd6);
        $display("after reset -> dout=%0d", q0[0].dout);

        // 4-beat window with bubbles between beats
        q0.delete();
        beat(1, 1, 1'b1, 1'b0);
        tick();
        beat(2, 2, 1'b0, 1'b0);
        tick();
        beat(3, 3, 1'b0, 1'b0);
        tick();
        beat(4, 4, 1'b0, 1'b1);
        wait_q(1);
        repeat (4) tick();
        chk("bubble_count", 32'(q0.size()),  32'd1);
        chk("bubble_dout",  32'(q0[0].dout), 32'd30);
        chk("bubble_sat",   32'(q0[0].sat),  32'd0);
        $display("bubbles -> dout=%0d", q0[0].dout);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
